// File: rtl/fifo_ctrl_pkg.sv
// Shared defaults and read-FSM state type for the 16x4 FIFO controller slice.
package fifo_ctrl_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 4;
    localparam int unsigned ADDR_WIDTH_DEF = 4;
    localparam int unsigned RAM_DEPTH_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fifo_ctrl_16x4_if.sv
// FIFO user-side handshake plus memory port bundle, with user/controller/memory views.
interface fifo_ctrl_16x4_if
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic                  push;
    logic [DATA_WIDTH-1:0] din;
    logic                  pop;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  rd_busy;
    logic [ADDR_WIDTH:0]   count;
    logic                  empty;
    logic                  full;
    logic                  overflow;
    logic                  underflow;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    modport master (
        output push, din, pop,
        input  dout, dout_valid, rd_busy, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, din, pop, mem_rd_data,
        output dout, dout_valid, rd_busy, count, empty, full, overflow, underflow,
        output mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr
    );

    modport mem (
        input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr,
        output mem_rd_data
    );

endinterface

// File: rtl/fifo_ctrl_16x4_ptr.sv
// Wrapping FIFO pointer: advances on i_en, returns to 0 after RAM_DEPTH-1.
module fifo_ptr
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned RAM_DEPTH  = RAM_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    output logic [ADDR_WIDTH-1:0] o_ptr
);
    logic [ADDR_WIDTH-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= (r_ptr == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : r_ptr + ADDR_WIDTH'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/memory_16x4.sv
// Simple dual-port storage with a registered read; contents are never reset.
module memory_16x4
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned RAM_DEPTH  = RAM_DEPTH_DEF
) (
    input logic            clk,
    fifo_ctrl_16x4_if.mem  bus
);
    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (bus.mem_wr_en) begin
            r_mem[bus.mem_wr_addr] <= bus.mem_wr_data;
        end
        if (bus.mem_rd_en) begin
            r_rd_data <= r_mem[bus.mem_rd_addr];
        end
    end

    assign bus.mem_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_ctrl_16x4.sv
// FIFO controller: pointer/count bookkeeping and a 3-state read FSM driving an
// external registered-read memory; holds no storage of its own.
module fifo_ctrl_16x4
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned RAM_DEPTH  = RAM_DEPTH_DEF
) (
    input logic             clk,
    input logic             rst,
    fifo_ctrl_16x4_if.slave bus
);
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    rd_state_t             r_state;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dout_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic                  w_capture;
    logic [ADDR_WIDTH-1:0] w_wr_ptr;
    logic [ADDR_WIDTH-1:0] w_rd_ptr;

    assign w_full    = (r_count == CNT_W'(RAM_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push_ok = bus.push & ~w_full & ~rst;
    assign w_pop_ok  = bus.pop & (r_state == IDLE) & ~w_empty;
    assign w_capture = (r_state == CAPTURE);

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH), .RAM_DEPTH(RAM_DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_push_ok),
        .o_ptr (w_wr_ptr)
    );

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH), .RAM_DEPTH(RAM_DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_capture),
        .o_ptr (w_rd_ptr)
    );

    // The entry under read stays counted until CAPTURE, so full blocks writes to it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            case (r_state)
                IDLE:    if (w_pop_ok) r_state <= FETCH;
                FETCH:   r_state <= CAPTURE;
                CAPTURE: begin
                    r_dout       <= bus.mem_rd_data;
                    r_dout_valid <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            case ({w_push_ok, w_capture})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (bus.push && w_full) r_overflow  <= 1'b1;
            if (bus.pop && !w_pop_ok) r_underflow <= 1'b1;
        end
    end

    assign bus.mem_wr_en   = w_push_ok;
    assign bus.mem_wr_addr = w_wr_ptr;
    assign bus.mem_wr_data = bus.din;
    assign bus.mem_rd_en   = (r_state != IDLE);
    assign bus.mem_rd_addr = w_rd_ptr;

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.rd_busy    = (r_state != IDLE);
    assign bus.count      = r_count;
    assign bus.empty      = w_empty;
    assign bus.full       = w_full;
    assign bus.overflow   = r_overflow;
    assign bus.underflow  = r_underflow;

endmodule

// File: tb/tb_fifo_ctrl_16x4.sv
// Bench for fifo_ctrl_16x4 paired with memory_16x4: vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_fifo_ctrl_16x4;
    import fifo_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    fifo_ctrl_16x4_if #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) bus ();

    fifo_ctrl_16x4 #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .RAM_DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    memory_16x4 #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .RAM_DEPTH(16)) u_mem (
        .clk (clk),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: FIFO contents as a queue; a read occupies the head until it is delivered.
    logic [3:0] m_q[$];
    int         m_inflight = 0;
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic       m_valid = 1'b0;
    logic [3:0] m_dout = 4'h0;
    logic       m_known = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic p, input logic [3:0] d, input logic pp);
        logic push_ok;
        logic pop_ok;
        if (r) begin
            m_q.delete();
            m_inflight = 0;
            m_ovf      = 1'b0;
            m_udf      = 1'b0;
            m_valid    = 1'b0;
            m_dout     = 4'h0;
            m_known    = 1'b1;
        end else begin
            push_ok = p && (m_q.size() < 16);
            pop_ok  = pp && (m_inflight == 0) && (m_q.size() > 0);
            if (p && !push_ok) m_ovf = 1'b1;
            if (pp && !pop_ok) m_udf = 1'b1;
            m_valid = 1'b0;
            if (m_inflight == 1) begin
                m_dout     = m_q.pop_front();
                m_valid    = 1'b1;
                m_inflight = 0;
            end else if (m_inflight == 2) begin
                m_inflight = 1;
            end
            if (push_ok) m_q.push_back(d);
            if (pop_ok) m_inflight = 2;
        end
    endtask

    task automatic check_outputs();
        chk("count",      32'(bus.count),   32'(m_q.size()));
        chk("empty",      32'(bus.empty),   32'(m_q.size() == 0));
        chk("full",       32'(bus.full),    32'(m_q.size() == 16));
        chk("dout_valid", 32'(bus.dout_valid), 32'(m_valid));
        chk("dout",       32'(bus.dout),    32'(m_dout));
        chk("rd_busy",    32'(bus.rd_busy), 32'(m_inflight > 0));
        chk("overflow",   32'(bus.overflow),  32'(m_ovf));
        chk("underflow",  32'(bus.underflow), 32'(m_udf));
    endtask

    // Drive one cycle of inputs, check the write/read strobes before the edge, then all outputs after.
    task automatic step(input logic r, input logic p, input logic [3:0] d, input logic pp);
        rst      = r;
        bus.push = p;
        bus.din  = d;
        bus.pop  = pp;
        #1;
        if (m_known) begin
            chk("mem_wr_en", 32'(bus.mem_wr_en), 32'(!r && p && (m_q.size() < 16)));
            chk("mem_rd_en", 32'(bus.mem_rd_en), 32'(m_inflight > 0));
            if (bus.mem_wr_en) chk("mem_wr_data", 32'(bus.mem_wr_data), 32'(d));
        end
        @(posedge clk);
        model_edge(r, p, d, pp);
        #1;
        check_outputs();
    endtask

    typedef struct {
        logic       rst;
        logic       push;
        logic [3:0] din;
        logic       pop;
        int         exp_count;
        logic       exp_valid;
        logic [3:0] exp_dout;
    } vec_t;

    vec_t vecs[10];

    initial begin
        rst = 1'b1; bus.push = 1'b0; bus.din = 4'h0; bus.pop = 1'b0;

        // Basic push/pop with the 3-edge read latency.
        vecs[0] = '{1'b1, 1'b0, 4'h0, 1'b0, 0, 1'b0, 4'h0};
        vecs[1] = '{1'b0, 1'b1, 4'h1, 1'b0, 1, 1'b0, 4'h0};
        vecs[2] = '{1'b0, 1'b1, 4'h2, 1'b0, 2, 1'b0, 4'h0};
        vecs[3] = '{1'b0, 1'b1, 4'h3, 1'b0, 3, 1'b0, 4'h0};
        vecs[4] = '{1'b0, 1'b0, 4'h0, 1'b1, 3, 1'b0, 4'h0};
        vecs[5] = '{1'b0, 1'b0, 4'h0, 1'b0, 3, 1'b0, 4'h0};
        vecs[6] = '{1'b0, 1'b0, 4'h0, 1'b0, 2, 1'b1, 4'h1};
        vecs[7] = '{1'b0, 1'b0, 4'h0, 1'b1, 2, 1'b0, 4'h1};
        vecs[8] = '{1'b0, 1'b0, 4'h0, 1'b0, 2, 1'b0, 4'h1};
        vecs[9] = '{1'b0, 1'b0, 4'h0, 1'b0, 1, 1'b1, 4'h2};
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].rst, vecs[i].push, vecs[i].din, vecs[i].pop);
            chk("vec_count", 32'(bus.count), 32'(vecs[i].exp_count));
            chk("vec_valid", 32'(bus.dout_valid), 32'(vecs[i].exp_valid));
            chk("vec_dout",  32'(bus.dout), 32'(vecs[i].exp_dout));
        end

        // Fill, overflow, drain in order with pointer wrap.
        step(1'b1, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'(i), 1'b0);
        chk("fill_full", 32'(bus.full), 32'd1);
        step(1'b0, 1'b1, 4'hA, 1'b0);
        chk("ovf_count", 32'(bus.count), 32'd16);
        chk("ovf_flag",  32'(bus.overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 4'h0, 1'b1);
            step(1'b0, 1'b0, 4'h0, 1'b0);
            step(1'b0, 1'b0, 4'h0, 1'b0);
            chk("drain_valid", 32'(bus.dout_valid), 32'd1);
            chk("drain_dout",  32'(bus.dout), 32'(i));
        end
        chk("drain_empty", 32'(bus.empty), 32'd1);
        chk("ovf_sticky",  32'(bus.overflow), 32'd1);
        step(1'b0, 1'b1, 4'h7, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        chk("wrap_dout", 32'(bus.dout), 32'h7);

        // Pop while empty, then a second pop while busy.
        step(1'b1, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        chk("udf_empty", 32'(bus.underflow), 32'd1);
        chk("udf_novalid", 32'(bus.dout_valid), 32'd0);
        step(1'b1, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b1, 4'h5, 1'b0);
        step(1'b0, 1'b1, 4'h6, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        chk("udf_busy", 32'(bus.underflow), 32'd1);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        chk("busy_count", 32'(bus.count), 32'd1);

        // Push coincident with CAPTURE at count 5.
        step(1'b1, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'(4'hA + i), 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b1, 4'h3, 1'b0);
        chk("coinc_count", 32'(bus.count), 32'd5);
        chk("coinc_dout",  32'(bus.dout), 32'hA);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 4'h0, 1'b1);
            step(1'b0, 1'b0, 4'h0, 1'b0);
            step(1'b0, 1'b0, 4'h0, 1'b0);
        end
        chk("coinc_last", 32'(bus.dout), 32'h3);

        // Reset during FETCH aborts the read.
        step(1'b0, 1'b0, 4'h0, 1'b1);
        step(1'b0, 1'b1, 4'h8, 1'b0);
        step(1'b0, 1'b1, 4'h9, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        step(1'b1, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        chk("abort_valid", 32'(bus.dout_valid), 32'd0);
        chk("abort_empty", 32'(bus.empty), 32'd1);
        chk("abort_udf",   32'(bus.underflow), 32'd0);
        step(1'b0, 1'b1, 4'hC, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        chk("abort_after", 32'(bus.dout), 32'hC);

        // Random traffic, alternating push-heavy and pop-heavy phases.
        for (int i = 0; i < 3000; i++) begin
            logic r, p, pp;
            int   push_pct;
            push_pct = ((i / 150) % 2 == 0) ? 70 : 25;
            r  = ($urandom_range(0, 199) == 0);
            p  = ($urandom_range(0, 99) < push_pct);
            pp = ($urandom_range(0, 99) < 100 - push_pct);
            step(r, p, 4'($urandom), pp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl_16x4.md
FIFO_CTRL_16X4 -- requirements
Module: fifo_ctrl_16x4

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, width of a FIFO entry.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, memory address width.
REQ-003 SHALL have parameter RAM_DEPTH, default 16, number of entries (2**ADDR_WIDTH).
REQ-004 SHALL have one clock and one reset: clk and rst; rst is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 push  input  1  write request, sampled each rising edge.
REQ-008 din  input  DATA_WIDTH  write data qualified by push.
REQ-009 pop  input  1  read request, sampled each rising edge.
REQ-010 dout  output  DATA_WIDTH  registered read data.
REQ-011 dout_valid  output  1  one-cycle pulse marking dout valid.
REQ-012 rd_busy  output  1  high while the read FSM is not IDLE.
REQ-013 count  output  ADDR_WIDTH+1  number of stored entries, 0..RAM_DEPTH.
REQ-014 empty / full  output  1 each  count==0 / count==RAM_DEPTH.
REQ-015 overflow / underflow  output  1 each  sticky error flags.
REQ-016 mem_wr_en, mem_wr_addr[ADDR_WIDTH], mem_wr_data[DATA_WIDTH]  output  drive the memory write port.
REQ-017 mem_rd_en, mem_rd_addr[ADDR_WIDTH]  output; mem_rd_data[DATA_WIDTH]  input  memory read port (1-cycle registered read, data gated by mem_rd_en).

Function
REQ-018 Write: mem_wr_en SHALL be push & ~full (combinational), mem_wr_addr = wr_ptr, mem_wr_data = din.
REQ-019 An accepted push SHALL increment wr_ptr modulo RAM_DEPTH and increment count at the same edge.
REQ-020 A push while full SHALL be dropped, with no memory write, and SHALL set overflow.
REQ-021 The read FSM SHALL have states IDLE, FETCH and CAPTURE.
REQ-022 In IDLE, pop with count>0 SHALL be accepted and move the FSM to FETCH.
REQ-023 A pop while empty or while rd_busy SHALL be dropped and SHALL set underflow.
REQ-024 In FETCH and CAPTURE, mem_rd_en SHALL be 1 and mem_rd_addr = rd_ptr; in IDLE, mem_rd_en SHALL be 0.
REQ-025 FETCH SHALL always go to CAPTURE after one cycle.
REQ-026 At the CAPTURE exit edge: dout <= mem_rd_data, dout_valid <= 1 for exactly one cycle, rd_ptr increments modulo RAM_DEPTH, count decrements, FSM returns to IDLE.
REQ-027 Latency: pop accepted at edge k SHALL give dout_valid high in the cycle after edge k+2; dout SHALL hold its value until the next capture.
REQ-028 Throughput: a new pop SHALL be acceptable in the same cycle dout_valid is high, giving at most one read per 3 cycles.
REQ-029 An entry being read SHALL stay counted until CAPTURE completes, so wr_ptr never equals an occupied rd_ptr.
REQ-030 No memory write SHALL ever target an address under read.
REQ-031 A push accepted at the same edge as a CAPTURE decrement SHALL leave count unchanged.
REQ-032 An entry written at edge k SHALL be poppable from the cycle after edge k.
REQ-033 Both pointers SHALL wrap from RAM_DEPTH-1 to 0.
REQ-034 overflow and underflow SHALL remain set until rst.

Reset
REQ-035 While rst is high at a rising edge: wr_ptr=0, rd_ptr=0, count=0, FSM=IDLE, dout=0, dout_valid=0, overflow=0, underflow=0.
REQ-036 Resulting reset outputs: empty=1, full=0, rd_busy=0, mem_rd_en=0.
REQ-037 rst SHALL override push and pop in the same cycle; mem_wr_en SHALL be 0 while rst is high.
REQ-038 A read in flight when rst asserts SHALL be aborted, with no dout_valid pulse.
REQ-039 Memory contents SHALL NOT be cleared by rst.

Structure
REQ-040 Package fifo_ctrl_pkg SHALL hold the DATA_WIDTH/ADDR_WIDTH/RAM_DEPTH defaults and the read-FSM state enum (IDLE, FETCH, CAPTURE).
REQ-041 The wrapping pointer counter SHALL be sub-module fifo_ptr (enable, rst, wrap at RAM_DEPTH-1), instanced for wr_ptr and rd_ptr.
REQ-042 The controller SHALL pair with memory_16x4 in a top-level FIFO wrapper; no storage SHALL live in the controller.

Verification
REQ-043 After reset, push 0x1..0x3 on consecutive cycles, then pop once -> dout_valid 3 cycles after the pop edge, dout=0x1, count 3->2.
REQ-044 Fill 16 entries, then one more push -> full=1, count=16, no mem write, overflow=1; pop all 16 -> data 0x0..0xF in order, pointers wrap, empty=1.
REQ-045 Pop while empty, and a second pop while rd_busy -> both ignored, underflow=1, no dout_valid.
REQ-046 count=5, push coincident with CAPTURE exit edge -> count stays 5, written data popped in FIFO order later.
REQ-047 rst asserted during FETCH -> no dout_valid, count=0, empty=1, all flags 0; the next push/pop sequence behaves as from power-up.
